// File: rtl/m_extension_pkg.sv
// Shared M-extension definitions: funct3 encodings, divider FSM states and
// small decode helpers used by the divider datapath.
package m_extension;

  typedef enum logic [2:0] {
    DIV  = 3'b100,
    DIVU = 3'b101,
    REM  = 3'b110,
    REMU = 3'b111
  } m_funct3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Signed variants treat operands as two's complement.
  function automatic logic is_signed_op(input logic [2:0] f);
    return (f == DIV) || (f == REM);
  endfunction

  // Remainder variants return the remainder instead of the quotient.
  function automatic logic is_rem_op(input logic [2:0] f);
    return (f == REM) || (f == REMU);
  endfunction

endpackage

// File: rtl/div_unit_pipe_step.sv
// div_step_comb: STEPS chained restoring-division steps, purely combinational.
// The remainder is kept WIDTH bits wide between steps; the shifted value is
// WIDTH+1 bits so the compare/subtract never overflows.
module div_step_comb
  import m_extension::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH-1:0] rem_chain [0:STEPS];
  logic [WIDTH-1:0] quo_chain [0:STEPS];

  assign rem_chain[0] = rem_i;
  assign quo_chain[0] = quo_i;

  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;
    // Bring the next dividend bit (MSB of the shift register) into the remainder.
    assign shifted = {rem_chain[gi], quo_chain[gi][WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_i};
    assign ge      = (shifted >= {1'b0, dvs_i});
    assign rem_chain[gi+1] = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_chain[gi+1] = {quo_chain[gi][WIDTH-2:0], ge};
  end

  assign rem_o = rem_chain[STEPS];
  assign quo_o = quo_chain[STEPS];

endmodule

// File: rtl/div_unit_pipe.sv
// div_unit_pipe: iterative restoring divider, STEPS quotient bits per cycle,
// valid/ready on both sides, flush, RISC-V div-by-zero/overflow semantics.
// Optional macro DIV_REM_FUSE_EN keeps the last completed operands and both
// results so a matching div/rem pair completes in one cycle.
module div_unit_pipe
  import m_extension::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int N_ITER = WIDTH / STEPS;
  localparam int CNT_W  = $clog2(N_ITER + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] step_rem, step_quo, fin_quo, fin_rem;
  logic [WIDTH-1:0] abs_dvd, abs_dvs, spec_quo, spec_rem;
  logic             req_signed, dvd_neg, dvs_neg, special;

  assign req_signed = is_signed_op(op);
  assign dvd_neg    = req_signed & dividend[WIDTH-1];
  assign dvs_neg    = req_signed & divisor[WIDTH-1];
  assign abs_dvd    = dvd_neg ? -dividend : dividend;
  assign abs_dvs    = dvs_neg ? -divisor : divisor;
  // Divide-by-zero and signed MIN / -1 bypass the iteration entirely.
  assign special    = (divisor == '0) ||
                      (req_signed && (dividend == MIN_VAL) && (divisor == '1));
  assign spec_quo   = (divisor == '0) ? '1 : MIN_VAL;
  assign spec_rem   = (divisor == '0) ? dividend : '0;
  assign fin_quo    = neg_quo_q ? -step_quo : step_quo;
  assign fin_rem    = neg_rem_q ? -step_rem : step_rem;

  div_step_comb #(.WIDTH(WIDTH), .STEPS(STEPS)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .quo_o(step_quo)
  );

`ifdef DIV_REM_FUSE_EN
  logic             tag_valid_q, tag_valid_d, tag_signed_q, tag_signed_d, tag_hit;
  logic [WIDTH-1:0] tag_dvd_q, tag_dvd_d, tag_dvs_q, tag_dvs_d;
  logic [WIDTH-1:0] tag_quo_q, tag_quo_d, tag_rem_q, tag_rem_d;
  logic [WIDTH-1:0] cur_dvd_q, cur_dvd_d, cur_dvs_q, cur_dvs_d;
  assign tag_hit = tag_valid_q && (tag_dvd_q == dividend) &&
                   (tag_dvs_q == divisor) && (tag_signed_q == req_signed);
`endif

  // Next-state and datapath update; flush overrides every state.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
`ifdef DIV_REM_FUSE_EN
    tag_valid_d  = tag_valid_q;
    tag_signed_d = tag_signed_q;
    tag_dvd_d    = tag_dvd_q;
    tag_dvs_d    = tag_dvs_q;
    tag_quo_d    = tag_quo_q;
    tag_rem_d    = tag_rem_q;
    cur_dvd_d    = cur_dvd_q;
    cur_dvs_d    = cur_dvs_q;
`endif
    if (flush) begin
      state_d = IDLE;
`ifdef DIV_REM_FUSE_EN
      tag_valid_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d      = op;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
            rem_d     = '0;
            quo_d     = abs_dvd;
            dvs_d     = abs_dvs;
            count_d   = CNT_W'(N_ITER);
`ifdef DIV_REM_FUSE_EN
            cur_dvd_d = dividend;
            cur_dvs_d = divisor;
`endif
            if (special) begin
              state_d  = DONE;
              result_d = is_rem_op(op) ? spec_rem : spec_quo;
`ifdef DIV_REM_FUSE_EN
              tag_valid_d  = 1'b1;
              tag_signed_d = req_signed;
              tag_dvd_d    = dividend;
              tag_dvs_d    = divisor;
              tag_quo_d    = spec_quo;
              tag_rem_d    = spec_rem;
`endif
            end
`ifdef DIV_REM_FUSE_EN
            else if (tag_hit) begin
              state_d  = DONE;
              result_d = is_rem_op(op) ? tag_rem_q : tag_quo_q;
            end
`endif
            else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d  = DONE;
            result_d = is_rem_op(op_q) ? fin_rem : fin_quo;
`ifdef DIV_REM_FUSE_EN
            tag_valid_d  = 1'b1;
            tag_signed_d = is_signed_op(op_q);
            tag_dvd_d    = cur_dvd_q;
            tag_dvs_d    = cur_dvs_q;
            tag_quo_d    = fin_quo;
            tag_rem_d    = fin_rem;
`endif
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
    end
  end

`ifdef DIV_REM_FUSE_EN
  // Fusion tag and the raw operands of the operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_q  <= 1'b0;
      tag_signed_q <= 1'b0;
      tag_dvd_q    <= '0;
      tag_dvs_q    <= '0;
      tag_quo_q    <= '0;
      tag_rem_q    <= '0;
      cur_dvd_q    <= '0;
      cur_dvs_q    <= '0;
    end else begin
      tag_valid_q  <= tag_valid_d;
      tag_signed_q <= tag_signed_d;
      tag_dvd_q    <= tag_dvd_d;
      tag_dvs_q    <= tag_dvs_d;
      tag_quo_q    <= tag_quo_d;
      tag_rem_q    <= tag_rem_d;
      cur_dvd_q    <= cur_dvd_d;
      cur_dvs_q    <= cur_dvs_d;
    end
  end
`endif

  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_div_unit_pipe.sv
// Scoreboard bench for div_unit_pipe: expected result and latency are pushed
// on acceptance and checked by a monitor when the unit presents a result.
module tb_div_unit_pipe;
  import m_extension::*;

  parameter int WIDTH = 32;
  parameter int STEPS = 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]       op;
  logic [WIDTH-1:0] dividend, divisor, result;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               acc;
    int               lat;
  } exp_t;
  exp_t sb_q[$];

  int   n_cmp = 0, n_err = 0, cyc = 0, first_cyc = 0;
  logic ov_prev = 1'b0;
  logic             tag_v = 1'b0, tag_s = 1'b0;
  logic [WIDTH-1:0] tag_a = '0, tag_b = '0;

  div_unit_pipe #(.WIDTH(WIDTH), .STEPS(STEPS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dividend(dividend), .divisor(divisor), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference division using the simulator's 64-bit arithmetic.
  function automatic logic [WIDTH-1:0] model(input logic [2:0] o,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic is_s, is_r;
    is_s = (o == DIV) || (o == REM);
    is_r = (o == REM) || (o == REMU);
    if (b == '0) return is_r ? a : '1;
    if (is_s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return is_r ? r[WIDTH-1:0] : q[WIDTH-1:0];
    end
    ua = longint'(a);
    ub = longint'(b);
    uq = ua / ub;
    ur = ua % ub;
    return is_r ? ur[WIDTH-1:0] : uq[WIDTH-1:0];
  endfunction

  // Monitor: latency on the rising edge of out_valid, result every valid cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_prev) begin
        first_cyc = cyc;
        if (sb_q.size() == 0) check("spurious_valid", 1'b1, 1'b0);
        else check("latency", 64'(cyc - sb_q[0].acc), 64'(sb_q[0].lat));
      end
      if (out_valid && sb_q.size() != 0) begin
        check("result", result, sb_q[0].res);
        check("in_ready_in_done", in_ready, 1'b0);
        if (out_ready) begin
          $display("[tb] txn result=%h exp=%h lat=%0d", result, sb_q[0].res,
                   first_cyc - sb_q[0].acc);
          void'(sb_q.pop_front());
        end
      end
    end
    ov_prev = out_valid;
  end

  // Drive a request at a negedge and push its expectation on acceptance.
  task automatic start_op(input logic [2:0] o, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
    exp_t e;
    logic is_s, hit;
    in_valid = 1'b1; op = o; dividend = a; divisor = b;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (in_ready) break;
      @(negedge clk);
    end
    if (!in_ready) check("accept", in_ready, 1'b1);
    is_s = (o == DIV) || (o == REM);
    hit  = 1'b0;
`ifdef DIV_REM_FUSE_EN
    hit = tag_v && (tag_a == a) && (tag_b == b) && (tag_s == is_s);
`endif
    e.res = model(o, a, b);
    e.acc = cyc;
    e.lat = (hit || b == '0 || (is_s && a == MIN_VAL && b == '1)) ? 1 : WIDTH / STEPS + 1;
    sb_q.push_back(e);
    tag_v = 1'b1; tag_a = a; tag_b = b; tag_s = is_s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); dividend = WIDTH'($urandom); divisor = WIDTH'($urandom);
  endtask

  // Wait for the scoreboard to drain, optionally stalling the consumer.
  task automatic finish_op(input int hold);
    if (hold > 0) begin
      for (int i = 0; i < 200 && !out_valid; i++) begin
        @(negedge clk); #1;
      end
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
    end
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check("done_wait", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    @(negedge clk); #1;
    check("idle_after", busy, 1'b0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int hold);
    out_ready = (hold == 0);
    start_op(o, a, b);
    finish_op(hold);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = '0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);

    run_op(DIVU, WIDTH'(100), WIDTH'(7), 0);
    run_op(REMU, WIDTH'(100), WIDTH'(7), 0);
    run_op(DIV,  WIDTH'(-7),  WIDTH'(2), 0);
    run_op(REM,  WIDTH'(-7),  WIDTH'(2), 0);
    run_op(REM,  WIDTH'(7),   WIDTH'(-2), 0);
    run_op(DIV,  WIDTH'(5),   WIDTH'(0), 0);
    run_op(REMU, WIDTH'(5),   WIDTH'(0), 0);
    run_op(REM,  MIN_VAL,     '1, 0);
    run_op(DIV,  MIN_VAL,     '1, 0);
    run_op(DIVU, WIDTH'(1000), WIDTH'(10), 5);

    // Flush mid-calculation with a competing request on the same cycle.
    out_ready = 1'b1;
    start_op(DIVU, WIDTH'(1000), WIDTH'(3));
    repeat (10) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = DIVU; dividend = WIDTH'(50); divisor = WIDTH'(5);
    #1;
    check("flush_in_ready", in_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    tag_v = 1'b0;
    #1;
    check("flush_busy", busy, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    repeat (40) @(negedge clk);
    run_op(DIVU, WIDTH'(9), WIDTH'(3), 0);

    // Same operands back to back (fused when the tag feature is built in).
    run_op(DIV, WIDTH'(100), WIDTH'(7), 0);
    run_op(REM, WIDTH'(100), WIDTH'(7), 0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]       o;
      logic [WIDTH-1:0] a, b;
      o = 3'(4 + $urandom_range(0, 3));
      a = WIDTH'($urandom);
      b = (i % 3 == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(1, 300));
      run_op(o, a, b, i % 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit_pipe.md
Name: div_unit_pipe

Overview:
- Parametrised iterative restoring divider for the M-extension execute stage.
- Successor to the single-width, one-bit-per-cycle divider.
- Adds:
  - WIDTH and bits-per-cycle parameters
  - valid/ready handshake on both sides
  - flush (kill) input
  - single result selected by op
  - full RISC-V div-by-zero and overflow semantics for all four ops

Parameters:
- WIDTH, 32, operand/result width; must be at least 8 and even.
- STEPS, 1, quotient bits resolved per cycle; legal values 1, 2, 4; WIDTH % STEPS == 0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  3  m_funct3 value: div, divu, rem, remu.
- dividend  in  WIDTH  rs1.
- divisor  in  WIDTH  rs2.
- flush  in  1  abandon any in-flight or held operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  quotient (div/divu) or remainder (rem/remu).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, async): state IDLE, out_valid 0, result 0, busy 0, in_ready 1 after release. All internal registers are cleared.
- States:
  - IDLE: in_ready = !flush. On in_valid && in_ready, latch op, operand signs and the absolute-value operands (signed ops only).
    - divisor == 0 -> go to DONE with quotient = all ones, remainder = dividend (raw, unsigned view).
    - Signed op with dividend == MIN (1 followed by zeros) and divisor == all ones -> go to DONE with quotient = MIN, remainder = 0.
    - Otherwise -> go to CALC with count = WIDTH/STEPS.
  - CALC: each cycle performs STEPS restoring steps (shift left, compare against |divisor|, subtract and set quotient bit), then decrements count. At count == 1 the next state is DONE. On the DONE-entry edge: quotient is negated if sign(dividend) ^ sign(divisor) on a signed op; remainder is negated if the dividend was negative on a signed op. result is registered from op.
  - DONE: out_valid = 1 and result is held stable. On out_ready the unit goes to IDLE next edge. A new request cannot be accepted in the same cycle (in_ready = 0 in DONE).
- Latency (accept edge to out_valid high):
  - normal: WIDTH/STEPS + 1 cycles (33 for defaults)
  - special cases: 1 cycle
- Throughput: one operation in flight.
- flush has priority over everything. In any state, the next edge goes to IDLE with out_valid = 0 and the result discarded. While flush is high, in_ready = 0, so a simultaneous in_valid is not accepted.
- result and out_valid only change on DONE entry or exit; inputs dividend/divisor/op are don't-care after acceptance.
- Width rules:
  - Partial remainder is WIDTH+1 bits internally, so the compare/subtract never overflows.
  - Negation is two's complement within WIDTH.

Optional Feature:
- Macro: DIV_REM_FUSE_EN.
- Defined:
  - A valid tag is kept holding the last completed operands, signedness, quotient and remainder.
  - A new request with identical dividend, divisor and signedness (div after rem, or divu after remu, or the reverse) skips CALC and goes to DONE in 1 cycle, returning the stored other result.
  - The tag is cleared by reset and by flush.
- Undefined: no tag storage; every request follows the normal path.

Decomposition:
- Package m_extension (existing): m_funct3 enum (div, divu, rem, remu); new div_state_e enum {IDLE, CALC, DONE}; helper function is_signed_op.
- Sub-module div_step_comb: purely combinational, parametrised by WIDTH and STEPS; inputs partial remainder, quotient shift register and divisor; outputs the next pair. Instantiated once in CALC.

Test Plan:
- divu 100 / 7, out_ready held 1 -> result 14 at accept+33 cycles; remu same operands -> 2.
- div 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); rem -> 0xFFFFFFFF (-1); rem 7 / -2 -> 1.
- div 5 / 0 -> 0xFFFFFFFF at accept+1; remu 5 / 0 -> 5; rem 0x80000000 / 0xFFFFFFFF -> 0; div same operands -> 0x80000000.
- Backpressure: divu 1000 / 10 with out_ready low for 5 cycles -> out_valid and result 100 stable; in_ready 0 throughout; IDLE one cycle after out_ready.
- Flush at CALC cycle 10, with in_valid also high -> out_valid never rises; the request is not accepted; next request divu 9 / 3 -> 3 with normal latency.
- STEPS=4, WIDTH=16 build: divu 0xFFFF / 0x0003 -> 0x5555 at accept+5. With DIV_REM_FUSE_EN: div 100 / 7 then rem 100 / 7 -> 2 at accept+1.
